// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Parametrised general-register file with NRD combinational
//                read ports, one synchronous write port and a per-register
//                busy scoreboard for RAW/WAW hazard detection in decode.
//                Register 0 is hard-wired to zero and is never busy.
//                Optional macro REGFILE_BYPASS_EN enables write-to-read
//                forwarding of data and busy state in the write cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                ip_clk,
    input  logic                ip_rst,
    input  logic [NRD*AW-1:0]   ip_rs_addr,
    output logic [NRD*XLEN-1:0] op_rs_data,
    output logic [NRD-1:0]      op_rs_busy,
    input  logic                ip_wr_en,
    input  logic [AW-1:0]       ip_wr_addr,
    input  logic [XLEN-1:0]     ip_wr_data,
    input  logic                ip_iss_en,
    input  logic [AW-1:0]       ip_iss_rd,
    output logic                op_iss_waw,
    output logic [AW:0]         op_pend_cnt
);

    // Storage. Entry 0 is never written, so it stays at its reset value of 0.
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_pend_cnt;

    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_pend_nxt;
    logic             w_wr_hit;

    // A writeback to x0 is discarded everywhere (storage, scoreboard, bypass).
    assign w_wr_hit = ip_wr_en && (ip_wr_addr != '0);

    // Decode issue/writeback into per-register set/clear masks; x0 excluded.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_set[r] = ip_iss_en && (ip_iss_rd == AW'(r));
            w_clr[r] = ip_wr_en && (ip_wr_addr == AW'(r));
        end
    end

    // Set dominates clear: a fresh producer issued in the writeback cycle of
    // the previous one keeps the register in flight.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    // Pending count is the population count of the next busy vector, so the
    // registered value always matches the scoreboard and cannot wrap.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_pend_nxt = w_pend_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    // Register array write port; reset clears every entry immediately.
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[ip_wr_addr] <= ip_wr_data;
        end
    end

    // Scoreboard and pending-count state.
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    assign op_pend_cnt = r_pend_cnt;

    // r_busy[0] is never set, so an issue to x0 can never report WAW.
    assign op_iss_waw = ip_iss_en && (ip_iss_rd != '0) && r_busy[ip_iss_rd];

    // Identical combinational read ports.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd_port
            logic [AW-1:0] w_addr;
            assign w_addr = ip_rs_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            logic w_fwd;
            assign w_fwd = w_wr_hit && (ip_wr_addr == w_addr);
            assign op_rs_data[k*XLEN +: XLEN] = w_fwd ? ip_wr_data : r_regs[w_addr];
            // A forwarded result is no longer pending unless re-issued now.
            assign op_rs_busy[k] = w_fwd ? (ip_iss_en && (ip_iss_rd == w_addr))
                                         : r_busy[w_addr];
`else
            assign op_rs_data[k*XLEN +: XLEN] = r_regs[w_addr];
            assign op_rs_busy[k]              = r_busy[w_addr];
`endif
        end
    endgenerate

endmodule
`default_nettype wire
